// File: rtl/fp_to_pcm.sv
// IEEE-754 single to signed PCM converter: 4-cycle FSM (UNPACK, SHIFT, PACK, DONE) with saturation.
// Build option FP_TO_PCM_ROUND_EN: round to nearest, ties away from zero (default truncates toward zero).
module fp_to_pcm #(
  parameter int OUT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [31:0]          in_data,
  output logic                 out_valid,
  output logic [OUT_WIDTH-1:0] pcm_out,
  output logic                 sat
);

  localparam int W = OUT_WIDTH;

  localparam logic [W+1:0] POS_LIM = (W+2)'((1 << (W-1)) - 1);
  localparam logic [W+1:0] NEG_LIM = (W+2)'(1 << (W-1));
  localparam logic [W-1:0] MAX_PCM = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0] MIN_PCM = {1'b1, {(W-1){1'b0}}};

  typedef enum logic [2:0] {IDLE, UNPACK, SHIFT, PACK, DONE} state_t;
  typedef enum logic [1:0] {C_NORM, C_ZERO, C_INF, C_NAN} cls_t;

  state_t state, next;

  logic [31:0]       data_q;
  logic              s_q;
  logic [23:0]       m_q;
  logic signed [9:0] sh_q;
  cls_t              cls_q;
  logic [W:0]        mag_q;
  logic              ovf_q;
`ifdef FP_TO_PCM_ROUND_EN
  logic              guard_q;
`endif

  // ---------------- control ----------------
  assign in_ready  = (state == IDLE) || (state == DONE);
  assign out_valid = (state == DONE);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= next;
  end

  always_comb begin
    next = state;
    case (state)
      IDLE:    next = in_valid ? UNPACK : IDLE;
      UNPACK:  next = SHIFT;
      SHIFT:   next = PACK;
      PACK:    next = DONE;
      DONE:    next = in_valid ? UNPACK : IDLE;
      default: next = IDLE;
    endcase
  end

  // ---------------- unpack ----------------
  logic [7:0]        e_in;
  logic [22:0]       f_in;
  logic signed [9:0] sh_n;
  cls_t              cls_n;

  assign e_in = data_q[30:23];
  assign f_in = data_q[22:0];
  // sh = 151 - W - e, so that M >> sh equals |v| * 2^(W-1)
  assign sh_n = $signed(10'(151 - W) - {2'b00, e_in});

  always_comb begin
    cls_n = C_NORM;
    if (e_in == 8'd0)        cls_n = C_ZERO;
    else if (e_in == 8'hFF)  cls_n = (f_in == 23'd0) ? C_INF : C_NAN;
  end

  // ---------------- shift ----------------
  logic [9:0]  nsh;
  logic [47:0] wide;
  logic        ovf_n;
`ifdef FP_TO_PCM_ROUND_EN
  logic [48:0] rsh;
  logic        guard_n;
`endif

  assign nsh = 10'd0 - $unsigned(sh_q);

  // Shift in a wide field; anything that does not fit W+1 bits is flagged
  // as overflow, which always saturates in PACK.
  always_comb begin
    wide  = '0;
    ovf_n = 1'b0;
`ifdef FP_TO_PCM_ROUND_EN
    rsh     = '0;
    guard_n = 1'b0;
`endif
    if (!sh_q[9]) begin
`ifdef FP_TO_PCM_ROUND_EN
      rsh     = {24'd0, m_q, 1'b0} >> $unsigned(sh_q);
      wide    = rsh[48:1];
      guard_n = rsh[0];
`else
      wide = {24'd0, m_q} >> $unsigned(sh_q);
`endif
    end else if (nsh > 10'(W)) begin
      ovf_n = 1'b1;
    end else begin
      wide = {24'd0, m_q} << nsh;
    end
    if (|wide[47:W]) ovf_n = 1'b1;
  end

  // ---------------- pack ----------------
  logic [W+1:0] mag_r;
  logic [W-1:0] pcm_n;
  logic         sat_n;

`ifdef FP_TO_PCM_ROUND_EN
  assign mag_r = {1'b0, mag_q} + {{(W+1){1'b0}}, guard_q};
`else
  assign mag_r = {1'b0, mag_q};
`endif

  always_comb begin
    pcm_n = '0;
    sat_n = 1'b0;
    case (cls_q)
      C_ZERO: begin
        pcm_n = '0;
        sat_n = 1'b0;
      end
      C_NAN: begin
        pcm_n = '0;
        sat_n = 1'b1;
      end
      C_INF: begin
        pcm_n = s_q ? MIN_PCM : MAX_PCM;
        sat_n = 1'b1;
      end
      default: begin
        if (!s_q && (ovf_q || mag_r > POS_LIM)) begin
          pcm_n = MAX_PCM;
          sat_n = 1'b1;
        end else if (s_q && (ovf_q || mag_r > NEG_LIM)) begin
          pcm_n = MIN_PCM;
          sat_n = 1'b1;
        end else begin
          // -2^(W-1) negates onto itself, which is exactly MIN_PCM
          pcm_n = s_q ? (~mag_r[W-1:0] + 1'b1) : mag_r[W-1:0];
        end
      end
    endcase
  end

  // ---------------- datapath registers ----------------
  always_ff @(posedge clk) begin
    if (reset) begin
      pcm_out <= '0;
      sat     <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: if (in_valid) data_q <= in_data;
        UNPACK: begin
          s_q   <= data_q[31];
          m_q   <= {1'b1, f_in};
          sh_q  <= sh_n;
          cls_q <= cls_n;
        end
        SHIFT: begin
          mag_q <= wide[W:0];
          ovf_q <= ovf_n;
`ifdef FP_TO_PCM_ROUND_EN
          guard_q <= guard_n;
`endif
        end
        PACK: begin
          pcm_out <= pcm_n;
          sat     <= sat_n;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/fp_to_pcm.md
Name: fp_to_pcm

Overview:
- Converts an IEEE-754 single-precision sample into a signed two's-complement PCM word for the audio codec interface.
- Sits directly downstream of the floating-point gain multiplier. Consumes its 32-bit product and feeds the DAC serializer.
- Full-scale mapping: float value v in [-1.0, 1.0) maps to round_toward_zero(v * 2^(OUT_WIDTH-1)), saturated to the output range.

Parameters:
- OUT_WIDTH, 16: PCM output width in bits. Legal range 8..24.

Ports:
- clk, input, 1: clock.
- reset, input, 1: synchronous, active-high reset.
- in_valid, input, 1: in_data is valid this cycle.
- in_ready, output, 1: block can accept a sample this cycle.
- in_data, input, 32: IEEE-754 single (sign[31], exp[30:23], mant[22:0]).
- out_valid, output, 1: one-cycle pulse; pcm_out and sat are valid.
- pcm_out, output, OUT_WIDTH: signed PCM result; held until the next result.
- sat, output, 1: result was clipped, or the input was Inf/NaN. Held with pcm_out.

Behaviour:
- Reset values: state=IDLE, pcm_out=0, sat=0, out_valid=0. in_ready follows state, so in_ready=1 out of reset.
- A reset asserted mid-conversion aborts it: no out_valid is produced, and pcm_out/sat are cleared to 0.
- FSM states: IDLE, UNPACK, SHIFT, PACK, DONE.
- in_ready = (state==IDLE) or (state==DONE).
- Accept: in_valid & in_ready at an edge latches in_data and moves to UNPACK. Otherwise IDLE stays IDLE and DONE goes to IDLE.
- UNPACK:
  - Register sign s, exponent e, and mantissa M = {1, mant} (24 bits).
  - Compute shift amount sh = 151 - OUT_WIDTH - e as a signed 10-bit value.
  - Classify the input as zero/denormal (e=0), Inf (e=255, mant=0), NaN (e=255, mant!=0), or normal.
- SHIFT:
  - If sh >= 0: mag = M >> sh, with mag=0 when sh > 24. Also register the guard bit (first bit shifted out) for the optional rounding.
  - If sh < 0: mag = M << -sh. Set the overflow flag when -sh > OUT_WIDTH or the shifted value exceeds the limit below.
  - Magnitude register is OUT_WIDTH+1 bits plus the overflow flag.
- PACK (registers pcm_out and sat):
  - Zero/denormal: pcm_out=0, sat=0.
  - NaN: pcm_out=0, sat=1.
  - Inf: pcm_out is max or min according to s, sat=1.
  - Positive with mag > 2^(W-1)-1: pcm_out = 2^(W-1)-1, sat=1.
  - Negative with mag > 2^(W-1): pcm_out = -2^(W-1), sat=1.
  - Otherwise: pcm_out = s ? -mag : mag, sat=0.
  - -0.0 yields 0.
- DONE: out_valid=1 for exactly one cycle.
- Latency: sample accepted at edge t gives out_valid high between edges t+3 and t+4. Next accept is possible at edge t+4 (during DONE). Sustained throughput is one sample per 4 cycles.
- in_data is ignored while in_ready=0. No backpressure on the output side.

Optional Feature:
- Macro: FP_TO_PCM_ROUND_EN.
- Defined: round to nearest, ties away from zero. Add the guard bit to mag in PACK, then apply the saturation checks. If rounding pushes mag past the limit, the result saturates with sat=1.
- Undefined: truncation toward zero. The guard bit is not generated.

Test Plan (OUT_WIDTH=16):
1. Accept 0x3F000000 (0.5) -> out_valid exactly 3 edges after accept; pcm_out=0x4000, sat=0. Then 0xBF400000 (-0.75) -> 0xA000, sat=0.
2. 0xBF800000 (-1.0) -> 0x8000, sat=0. 0x3F800000 (+1.0) -> 0x7FFF, sat=1. 0x42C80000 (100.0) -> 0x7FFF, sat=1.
3. 0x38000000 (2^-15) -> 0x0001. 0x37800000 (2^-16) -> 0x0000 truncating; 0x0001 with FP_TO_PCM_ROUND_EN. 0xB7800000 -> 0x0000 truncating; 0xFFFF with rounding.
4. Specials: 0x00000000 and 0x80000000 -> 0, sat=0. 0x00400000 (denormal) -> 0, sat=0. 0x7F800000 -> 0x7FFF, sat=1. 0xFF800000 -> 0x8000, sat=1. 0x7FC00000 -> 0, sat=1.
5. Hold in_valid=1 with 4 distinct samples -> accepts on every 4th edge, one out_valid pulse per sample, in order. in_ready low in UNPACK/SHIFT/PACK.
6. Assert reset during SHIFT -> no out_valid; pcm_out=0, sat=0, in_ready=1 on the next cycle. A following sample converts correctly.
